// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared constants and types for the VGA controller position
//                counters (horizontal and vertical).
//                Contents:
//                  VGA_CNT_WIDTH - default counter width (10 bits)
//                  vga_count_t   - count value type of that width
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int VGA_CNT_WIDTH = 10;

    typedef logic [VGA_CNT_WIDTH-1:0] vga_count_t;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_counter_if
//  Description : Control/data bundle for one vga_counter.
//                Signals:
//                  Count - increment enable
//                  Load  - parallel-load enable
//                  D     - parallel load value
//                  Q     - registered count
//                Modports:
//                  master - drives Count/Load/D, observes Q
//                  slave  - the counter itself
//                Clock and Clear stay outside the bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_counter_if
    import vga_pkg::*;
#(
    parameter int WIDTH = VGA_CNT_WIDTH
);

    logic             Count;
    logic             Load;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;

    modport master (
        output Count,
        output Load,
        output D,
        input  Q
    );

    modport slave (
        input  Count,
        input  Load,
        input  D,
        output Q
    );

endinterface : vga_counter_if
`default_nettype wire

// File: rtl/vga_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_counter
//  Description : Loadable, clearable WIDTH-bit up-counter used as the
//                horizontal/vertical position counter of the VGA controller.
//                Priority at each rising Clock edge:
//                  Clear > Load > Count > hold
//                Ports (positional order is fixed):
//                  Count  in   1      increment enable
//                  Load   in   1      parallel-load enable
//                  Clear  in   1      synchronous active-high clear
//                  Clock  in   1      rising-edge clock
//                  D      in   WIDTH  parallel load value
//                  Q      out  WIDTH  registered count
//                Build option:
//                  VGA_COUNTER_SAT_EN - when defined the increment saturates
//                  at all-ones; otherwise it wraps to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_counter
    import vga_pkg::*;
#(
    parameter int WIDTH = VGA_CNT_WIDTH
) (
    input  wire logic             Count,
    input  wire logic             Load,
    input  wire logic             Clear,
    input  wire logic             Clock,
    input  wire logic [WIDTH-1:0] D,
    output logic      [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_inc;

`ifdef VGA_COUNTER_SAT_EN
    // All-ones is sticky under Count; only Clear or Load leaves it.
    assign count_inc = (count_q == {WIDTH{1'b1}}) ? count_q
                                                  : count_q + WIDTH'(1);
`else
    // Carry-out is dropped, so all-ones rolls over to zero.
    assign count_inc = count_q + WIDTH'(1);
`endif

    always_ff @(posedge Clock) begin
        if (Clear) begin
            count_q <= '0;
        end else if (Load) begin
            count_q <= D;
        end else if (Count) begin
            count_q <= count_inc;
        end
    end

    // Q is the register itself: no input reaches it combinationally.
    assign Q = count_q;

endmodule : vga_counter
`default_nettype wire

// File: tb/tb_vga_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_counter
//  Description : Self-checking bench for vga_counter: directed vector table,
//                hand-written multi-cycle sequences and randomized traffic
//                against an arithmetic reference model.
//                Honours VGA_COUNTER_SAT_EN for the all-ones behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_counter;
    import vga_pkg::*;

    localparam int W    = VGA_CNT_WIDTH;
    localparam int MODV = 1 << W;

    logic clk;
    logic clear;

    vga_counter_if #(.WIDTH(W)) bus ();

    vga_counter #(.WIDTH(W)) dut (
        .Count (bus.Count),
        .Load  (bus.Load),
        .Clear (clear),
        .Clock (clk),
        .D     (bus.D),
        .Q     (bus.Q)
    );

    // Period 50, rising edges at 25, 75, 125, ...
    initial begin
        clk = 1'b0;
        forever #25 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int model  = 0;   // expected count, plain integer arithmetic

    typedef struct {
        bit          clr;
        bit          ld;
        bit          cnt;
        int          d;
        int          exp;
        string       name;
    } vec_t;

    vec_t vecs[16];

    function automatic int ref_next(int cur, bit c, bit l, bit n, int d);
        if (c) return 0;
        if (l) return d % MODV;
        if (n) begin
`ifdef VGA_COUNTER_SAT_EN
            if (cur == MODV - 1) return cur;
`endif
            return (cur + 1) % MODV;
        end
        return cur;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: Q=%0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive controls well before the edge, then sample 1 time unit after it.
    task automatic apply(input bit c, input bit l, input bit n, input int d);
        clear     = c;
        bus.Load  = l;
        bus.Count = n;
        bus.D     = W'(d);
        @(posedge clk);
        #1;
        model = ref_next(model, c, l, n, d);
    endtask

    initial begin
        int sat_a;
        int sat_b;
`ifdef VGA_COUNTER_SAT_EN
        sat_a = 1023; sat_b = 1023;
`else
        sat_a = 0;    sat_b = 1;
`endif
        //            clr ld cnt  d      exp    name
        vecs[0]  = '{1, 0, 0, 0,     0,     "reset_clear"};
        vecs[1]  = '{0, 1, 0, 'h1A8, 424,   "load_1A8"};
        vecs[2]  = '{0, 0, 1, 'h1A8, 425,   "count1"};
        vecs[3]  = '{0, 0, 1, 'h1A8, 426,   "count2"};
        vecs[4]  = '{0, 0, 1, 'h1A8, 427,   "count3"};
        vecs[5]  = '{0, 0, 0, 'h1A8, 427,   "hold427"};
        vecs[6]  = '{1, 0, 0, 'h1A8, 0,     "clear_mid"};
        vecs[7]  = '{1, 0, 0, 'h1AB, 0,     "clear_d_change"};
        vecs[8]  = '{0, 1, 0, 'h1AB, 427,   "load_1AB"};
        vecs[9]  = '{1, 1, 1, 'h1AB, 0,     "clear_beats_all"};
        vecs[10] = '{0, 1, 1, 5,     5,     "load_beats_count"};
        vecs[11] = '{0, 1, 0, 1022,  1022,  "load_1022"};
        vecs[12] = '{0, 0, 1, 0,     1023,  "to_max"};
        vecs[13] = '{0, 0, 1, 0,     sat_a, "wrap_or_sat1"};
        vecs[14] = '{0, 0, 1, 0,     sat_b, "wrap_or_sat2"};
        vecs[15] = '{0, 1, 0, 300,   300,   "load_300"};

        clear     = 1'b0;
        bus.Load  = 1'b0;
        bus.Count = 1'b0;
        bus.D     = '0;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].clr, vecs[i].ld, vecs[i].cnt, vecs[i].d);
            check(vecs[i].name, int'(bus.Q), vecs[i].exp);
        end

        // Hold for 10 edges with D wandering while Load is low
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 0, int'($urandom_range(0, MODV - 1)));
            check("hold300", int'(bus.Q), 300);
        end

        // Load pulse lying entirely between edges must be ignored
        #5;
        bus.Load = 1'b1;
        bus.D    = W'(77);
        #10;
        bus.Load = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_load_ignored", int'(bus.Q), 300);

        // Clear held with Count high, then counting resumes from 0
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 1, 0);
            check("clear_held", int'(bus.Q), 0);
        end
        apply(0, 0, 1, 0);
        check("resume1", int'(bus.Q), 1);
        apply(0, 0, 1, 0);
        check("resume2", int'(bus.Q), 2);

        // Randomized traffic against the reference model; periodic loads
        // near the top of the range exercise the wrap/saturate boundary.
        for (int i = 0; i < 400; i++) begin
            bit c, l, n;
            int d;
            c = ($urandom_range(0, 15) == 0);
            l = ($urandom_range(0, 7) == 0);
            n = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 1) == 0) ? int'($urandom_range(MODV - 4, MODV - 1))
                                            : int'($urandom_range(0, MODV - 1));
            apply(c, l, n, d);
            check("random", int'(bus.Q), model);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vga_counter
`default_nettype wire
